// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the uart-to-memory command bridge.
// Optional build macro used by the bridge: UART_BRIDGE_TIMEOUT_EN.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_READ,
    S_RWAIT,
    S_SEND
  } state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;
  localparam logic [7:0] DEFAULT_ACK = 8'h4B;
  localparam logic [7:0] DEFAULT_NAK = 8'h3F;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_bridge_txser.sv
// Response byte serializer: loads up to 4 bytes, presents them MSB first
// and holds each byte stable until the uart accepts it.
module uart_bridge_txser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last
);

  logic [31:0] shift_q;
  logic [2:0]  count_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      count_q <= load_count;
      valid_q <= (load_count != 3'd0);
    end else if (valid_q && tx_ready) begin
      shift_q <= {shift_q[23:0], 8'h00};
      count_q <= count_q - 3'd1;
      if (count_q == 3'd1)
        valid_q <= 1'b0;
    end
  end

  always_comb begin
    tx_data  = shift_q[31:24];
    tx_valid = valid_q;
    last     = valid_q && tx_ready && (count_q == 3'd1);
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// Host command parser: 'W' addr(2) data(4) writes a word, 'R' addr(2) reads one.
// Build macro UART_BRIDGE_TIMEOUT_EN adds an inactivity timeout on partial frames.
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [7:0]  ACK_BYTE   = DEFAULT_ACK,
  parameter logic [7:0]  NAK_BYTE   = DEFAULT_NAK
`ifdef UART_BRIDGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 10_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t                state;
  logic [7:0]            opcode;
  logic [1:0]            byte_cnt;
  logic [15:0]           addr_sr;
  logic [15:0]           addr_next;
  logic [DATA_WIDTH-1:0] wdata_sr;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rx_fire;
  logic                  timeout;
  logic                  tx_load;
  logic [31:0]           tx_load_data;
  logic [2:0]            tx_load_count;
  logic                  tx_last;

  always_comb begin
    rx_ready   = !rst && (state == S_IDLE || state == S_ADDR || state == S_WDATA);
    rx_fire    = rx_valid && rx_ready;
    busy       = (state != S_IDLE);
    mem_we     = (state == S_WRITE);
    mem_re     = (state == S_READ);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    addr_next  = {addr_sr[7:0], rx_data};
    wdata_next = {wdata_sr[DATA_WIDTH-9:0], rx_data};
  end

  always_comb begin
    tx_load       = 1'b0;
    tx_load_data  = '0;
    tx_load_count = '0;
    case (state)
      S_IDLE: begin
        if (rx_fire && rx_data != CMD_WRITE && rx_data != CMD_READ) begin
          tx_load       = 1'b1;
          tx_load_data  = {NAK_BYTE, 24'h000000};
          tx_load_count = 3'd1;
        end
      end
      S_WRITE: begin
        tx_load       = 1'b1;
        tx_load_data  = {ACK_BYTE, 24'h000000};
        tx_load_count = 3'd1;
      end
      S_RWAIT: begin
        tx_load       = 1'b1;
        tx_load_data  = mem_rdata;
        tx_load_count = 3'(BYTES_PER_WORD);
      end
      default: ;
    endcase
  end

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        in_frame;

  always_comb begin
    in_frame = (state == S_ADDR || state == S_WDATA);
    timeout  = in_frame && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || rx_fire || !in_frame)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 32'd1;
  end
`else
  always_comb timeout = 1'b0;
`endif

  // mem_addr/mem_wdata only update on entry to an access state, so they hold between accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      opcode   <= '0;
      byte_cnt <= '0;
      addr_sr  <= '0;
      wdata_sr <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              opcode   <= rx_data;
              byte_cnt <= '0;
              state    <= S_ADDR;
            end else begin
              state <= S_SEND;
            end
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_sr <= addr_next;
            if (byte_cnt == 2'd1) begin
              byte_cnt <= '0;
              if (opcode == CMD_WRITE) begin
                state <= S_WDATA;
              end else begin
                addr_q <= addr_next[ADDR_WIDTH-1:0];
                state  <= S_READ;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            wdata_sr <= wdata_next;
            if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
              byte_cnt <= '0;
              addr_q   <= addr_sr[ADDR_WIDTH-1:0];
              wdata_q  <= wdata_next;
              state    <= S_WRITE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (timeout) begin
            state <= S_IDLE;
          end
        end
        S_WRITE: state <= S_SEND;
        S_READ:  state <= S_RWAIT;
        S_RWAIT: state <= S_SEND;
        S_SEND: begin
          if (tx_last)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_bridge_txser u_txser (
    .clk        (clk),
    .rst        (rst),
    .load       (tx_load),
    .load_data  (tx_load_data),
    .load_count (tx_load_count),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .last       (tx_last)
  );

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Self-checking bench for uart_mem_bridge: table-driven frames plus hand-written
// corner sequences; a scoreboard checks memory strobes and tx bytes.
module tb_uart_mem_bridge;

  localparam int unsigned AW = 4;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h3F;
  localparam logic [7:0] CW  = 8'h57;
  localparam logic [7:0] CR  = 8'h52;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [31:0]   mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  uart_mem_bridge #(
    .ADDR_WIDTH (AW),
    .ACK_BYTE   (ACK),
    .NAK_BYTE   (NAK)
`ifdef UART_BRIDGE_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory seen by the DUT, and the bench's own reference of what it should hold.
  logic [31:0] sim_mem [16] = '{default: '0};
  logic [31:0] exp_mem [16] = '{default: '0};

  always @(posedge clk) begin
    if (mem_we) sim_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sim_mem[mem_addr];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0]    cmd;
    logic [15:0]   addr;
    logic [31:0]   data;
    logic [AW-1:0] exp_addr;
  } vec_t;

  wr_t           exp_wr [$];
  logic [AW-1:0] exp_rd [$];
  logic [7:0]    exp_tx [$];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int wr_expected = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk_eq("we_re_exclusive", {31'b0, mem_we && mem_re}, 32'd0);
      if (mem_we) begin
        wr_seen++;
        chk_eq("write_expected", {31'b0, exp_wr.size() > 0}, 32'd1);
        if (exp_wr.size() > 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk_eq("write_addr", {28'b0, mem_addr}, {28'b0, w.addr});
          chk_eq("write_data", mem_wdata, w.data);
        end
      end
      if (mem_re) begin
        chk_eq("read_expected", {31'b0, exp_rd.size() > 0}, 32'd1);
        if (exp_rd.size() > 0) begin
          logic [AW-1:0] a;
          a = exp_rd.pop_front();
          chk_eq("read_addr", {28'b0, mem_addr}, {28'b0, a});
        end
      end
      if (tx_valid && tx_ready) begin
        chk_eq("tx_expected", {31'b0, exp_tx.size() > 0}, 32'd1);
        if (exp_tx.size() > 0) begin
          logic [7:0] b;
          b = exp_tx.pop_front();
          chk_eq("tx_byte", {24'b0, tx_data}, {24'b0, b});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 500) begin
        chk_eq("rx_accept", {31'b0, rx_ready}, 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (!busy && !tx_valid && exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0)
        break;
      n++;
    end
    chk_eq("idle_busy", {31'b0, busy}, 32'd0);
    chk_eq("tx_drained", exp_tx.size(), 32'd0);
    chk_eq("mem_drained", exp_wr.size() + exp_rd.size(), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] bytes [$];
    logic [31:0] d;
    bytes.push_back(v.cmd);
    if (v.cmd == CW || v.cmd == CR) begin
      bytes.push_back(v.addr[15:8]);
      bytes.push_back(v.addr[7:0]);
    end
    if (v.cmd == CW) begin
      for (int unsigned i = 0; i < 4; i++) bytes.push_back(v.data[31 - 8*i -: 8]);
      exp_wr.push_back('{addr: v.exp_addr, data: v.data});
      exp_mem[v.exp_addr] = v.data;
      wr_expected++;
      exp_tx.push_back(ACK);
    end else if (v.cmd == CR) begin
      exp_rd.push_back(v.exp_addr);
      d = exp_mem[v.exp_addr];
      for (int unsigned i = 0; i < 4; i++) exp_tx.push_back(d[31 - 8*i -: 8]);
    end else begin
      exp_tx.push_back(NAK);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
    @(negedge clk);
    if (v.cmd == CW) begin
      chk_eq("write_latency", {31'b0, mem_we}, 32'd1);
      @(negedge clk);
      chk_eq("write_pulse_width", {31'b0, mem_we}, 32'd0);
      chk_eq("ack_latency", {31'b0, tx_valid}, 32'd1);
    end else if (v.cmd == CR) begin
      chk_eq("read_latency", {31'b0, mem_re}, 32'd1);
      @(negedge clk);
      chk_eq("read_pulse_width", {31'b0, mem_re}, 32'd0);
      chk_eq("read_tx_early", {31'b0, tx_valid}, 32'd0);
      @(negedge clk);
      chk_eq("read_tx_latency", {31'b0, tx_valid}, 32'd1);
    end else begin
      chk_eq("nak_latency", {31'b0, tx_valid}, 32'd1);
    end
    wait_idle();
  endtask

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{cmd: CW,    addr: 16'h0005, data: 32'hDEADBEEF, exp_addr: 4'h5};
    vecs[1] = '{cmd: CR,    addr: 16'h0005, data: 32'h0,        exp_addr: 4'h5};
    vecs[2] = '{cmd: CW,    addr: 16'hFFF3, data: 32'h12345678, exp_addr: 4'h3};
    vecs[3] = '{cmd: CR,    addr: 16'h0003, data: 32'h0,        exp_addr: 4'h3};
    vecs[4] = '{cmd: CW,    addr: 16'h0000, data: 32'hFFFFFFFF, exp_addr: 4'h0};
    vecs[5] = '{cmd: CW,    addr: 16'h000F, data: 32'h00000000, exp_addr: 4'hF};
    vecs[6] = '{cmd: CR,    addr: 16'h000F, data: 32'h0,        exp_addr: 4'hF};
    vecs[7] = '{cmd: CR,    addr: 16'hABC0, data: 32'h0,        exp_addr: 4'h0};
    vecs[8] = '{cmd: 8'h41, addr: 16'h0000, data: 32'h0,        exp_addr: 4'h0};
    vecs[9] = '{cmd: CR,    addr: 16'h0000, data: 32'h0,        exp_addr: 4'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk_eq("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk_eq("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk_eq("rst_mem_addr", {28'b0, mem_addr}, 32'd0);
    chk_eq("rst_mem_wdata", mem_wdata, 32'd0);
    chk_eq("rst_mem_strobes", {30'b0, mem_we, mem_re}, 32'd0);
    chk_eq("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("idle_rx_ready", {31'b0, rx_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // mem_addr/mem_wdata hold the last access values while idle.
    chk_eq("hold_addr", {28'b0, mem_addr}, 32'd0);
    chk_eq("hold_wdata", mem_wdata, 32'h00000000);

    // Tx backpressure during a read response.
    tx_ready = 1'b0;
    exp_rd.push_back(4'h5);
    for (int unsigned i = 0; i < 4; i++) exp_tx.push_back(exp_mem[5][31 - 8*i -: 8]);
    send_byte(CR);
    send_byte(8'h00);
    send_byte(8'h05);
    begin
      int n;
      n = 0;
      while (!tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_eq("stall_tx_data", {24'b0, tx_data}, {24'b0, exp_mem[5][31:24]});
      chk_eq("stall_tx_valid", {31'b0, tx_valid}, 32'd1);
      chk_eq("stall_rx_ready", {31'b0, rx_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_idle();

    // Reset mid-frame discards the partial write.
    send_byte(CW);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_eq("midrst_rx_ready", {31'b0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("midrst_busy", {31'b0, busy}, 32'd0);
    run_vec('{cmd: CR, addr: 16'h0001, data: 32'h0, exp_addr: 4'h1});

`ifdef UART_BRIDGE_TIMEOUT_EN
    send_byte(CW);
    send_byte(8'h00);
    repeat (90) @(negedge clk);
    chk_eq("timeout_not_yet", {31'b0, busy}, 32'd1);
    repeat (12) @(negedge clk);
    chk_eq("timeout_idle", {31'b0, busy}, 32'd0);
    chk_eq("timeout_no_tx", {31'b0, tx_valid}, 32'd0);
    run_vec('{cmd: CR, addr: 16'h0002, data: 32'h0, exp_addr: 4'h2});
`endif

    repeat (5) @(negedge clk);
    chk_eq("write_count", wr_seen, wr_expected);
    chk_eq("final_busy", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Byte-stream command responder that sits on the host side of the uart block's valid/ready byte interface.
- Parses write/read commands from the host PC and issues single-cycle word accesses on the RSA CPU data-memory load port.
- Returns an acknowledge byte (write) or the read word (read) through the uart transmit byte interface.
- Used to load keys and ciphertext into memory and read results back out.

Parameters:
- ADDR_WIDTH, 16: word address width; must be between 1 and 16.
- DATA_WIDTH, 32: memory word width; fixed at 32 (4 bytes per word).
- ACK_BYTE, 8'h4B: byte sent after a completed write.
- NAK_BYTE, 8'h3F: byte sent for an unknown command byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte, from the uart rx_data.
- rx_valid  in  1  received byte valid.
- rx_ready  out  1  bridge can accept a byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  uart can accept a byte.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  write data.
- mem_we  out  1  write strobe, 1 cycle.
- mem_re  out  1  read strobe, 1 cycle.
- mem_rdata  in  32  read data, valid 1 cycle after mem_re.
- busy  out  1  high in every state other than S_IDLE.

Behaviour:
- Reset state: S_IDLE. All outputs 0: rx_ready, tx_valid, tx_data, mem_*, busy.
- Reset mid-command: the partial command is discarded and no memory strobe is issued.
- Rx handshake: a byte is consumed on the cycle rx_valid && rx_ready.
  - rx_ready = 1 only in S_IDLE, S_ADDR and S_WDATA.
- Tx handshake: once tx_valid rises, tx_data is held stable and tx_valid stays high until the cycle tx_valid && tx_ready.
- Frame format (all multi-byte fields big-endian):
  - Write: 'W'(8'h57), addr_hi, addr_lo, d3, d2, d1, d0.
  - Read: 'R'(8'h52), addr_hi, addr_lo.
  - Address = {addr_hi, addr_lo}[ADDR_WIDTH-1:0]; upper bits are ignored.
- FSM states and transitions:
  - S_IDLE:
    - 'W' or 'R' → latch the opcode, clear the byte counter, go to S_ADDR.
    - Any other byte → load NAK_BYTE, go to S_SEND with 1 byte.
  - S_ADDR: shift in 2 bytes. After the 2nd byte → S_WDATA if opcode is 'W', else S_READ.
  - S_WDATA: shift 4 bytes into a 32-bit shift register, MSB first. After the 4th byte → S_WRITE.
  - S_WRITE: mem_we = 1 for exactly one cycle with mem_addr/mem_wdata. Load ACK_BYTE, go to S_SEND with 1 byte.
  - S_READ: mem_re = 1 for exactly one cycle → S_RWAIT.
  - S_RWAIT: capture mem_rdata into the tx shift register → S_SEND with 4 bytes.
  - S_SEND: present the top byte. On each tx handshake, shift left 8 bits and decrement the count. After the last byte → S_IDLE.
- Latency:
  - Last write byte accepted → mem_we on the next cycle.
  - Ack tx_valid rises the cycle after mem_we.
  - Last read address byte → mem_re next cycle; tx_valid rises 2 cycles after mem_re.
- mem_addr and mem_wdata hold their last values between accesses. mem_we and mem_re are never high simultaneously.
- tx_ready held low indefinitely: the bridge stalls in S_SEND and rx_ready stays 0 (backpressure to the host).
- Bytes arriving while rx_ready = 0 are left to the uart rx buffer; the bridge never drops them itself.

Optional Feature:
- Macro: UART_BRIDGE_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 10_000_000) and a counter that clears on every accepted byte.
  - The counter runs only while in S_ADDR or S_WDATA.
  - When the counter reaches TIMEOUT_CYCLES-1, the FSM returns to S_IDLE with no memory strobe and no tx byte.
- Undefined: there is no counter; a partial command waits forever.

Decomposition:
- Package uart_bridge_pkg holds:
  - The state enum typedef.
  - Constants CMD_WRITE = 8'h57, CMD_READ = 8'h52, default ACK/NAK bytes.
  - BYTES_PER_WORD = 4.
- One natural sub-module: uart_bridge_txser, the S_SEND byte serializer (32-bit shift register, count, valid/ready hold). The FSM and rx parsing stay in the top module.

Test Plan:
- Write, no stall: send 57 00 05 DE AD BE EF with tx_ready = 1 → one mem_we pulse with mem_addr = 5, mem_wdata = 32'hDEADBEEF; tx byte 4B follows; busy returns to 0.
- Read: send 52 00 05, model mem_rdata = 32'hDEADBEEF → one mem_re pulse with addr 5; tx bytes DE, AD, BE, EF in that order.
- Tx backpressure: during a read response, hold tx_ready = 0 for 20 cycles → tx_data stays DE with tx_valid high, rx_ready = 0; after release, all 4 bytes are sent once each.
- Unknown command: send 41 → tx 3F; the next 52 00 00 is parsed normally.
- Reset mid-frame: send 57 00 01 AA, assert rst for 1 cycle, then send 52 00 01 → no mem_we ever occurs; the read completes.
- Timeout (macro defined, TIMEOUT_CYCLES = 100): send 57 00, then idle 100 cycles → FSM returns to S_IDLE, busy = 0, no tx; a subsequent 52 00 02 works.
